mram_ctrl: RTL and testbench

MRAM_CTRL -- requirements
Module: mram_ctrl

---
 rtl/mram_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mram_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mram_ctrl.sv
// -----------------------------------------------------------------------------
// mram_ctrl -- power-managed single-outstanding MRAM access controller.
//
// Sequences MRAM power-up (OFF -> WAKE -> IDLE), accepts one host request at a
// time, drives a single-cycle MRAM access strobe and returns a one-cycle
// response pulse. Misaligned requests are answered with an error without
// touching the MRAM. Power-down requests are deferred until any open
// transaction has produced its response.
//
// Optional feature macro: MRAM_CTRL_TIMEOUT_EN
//    defined   : a read waiting longer than TIMEOUT_CYCLES cycles for
//                mram_ready is answered with rsp_err=1, rsp_rdata=0.
//    undefined : a read waits for mram_ready indefinitely.
//
// Ports:
//    clk, rst            clock and synchronous active-high reset
//    pwr_req / pwr_ok    host power request / powered-and-settled status
//    req_*               host request channel (valid/ready handshake)
//    rsp_*               host response (one-cycle pulse, no backpressure)
//    mram_*              MRAM power, chip select, strobes, address and data
// -----------------------------------------------------------------------------
module mram_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int WAKE_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pwr_req,
   output logic                  pwr_ok,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  mram_pwr_on,
   output logic                  mram_cs,
   output logic                  mram_write_en,
   output logic                  mram_read_en,
   output logic [ADDR_WIDTH-1:0] mram_addr,
   output logic [DATA_WIDTH-1:0] mram_wdata,
   input  logic [DATA_WIDTH-1:0] mram_rdata,
   input  logic                  mram_ready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int WK_W  = $clog2(WAKE_CYCLES + 1);

   // Parameter sanity: an illegal configuration elaborates an empty marker block.
   if ((WAKE_CYCLES < 1) || (TIMEOUT_CYCLES < 1) || (DATA_WIDTH < 8) ||
       ((DATA_WIDTH % 8) != 0)) begin : g_bad_params
   end

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_WAKE  = 3'd1,
      S_IDLE  = 3'd2,
      S_ISSUE = 3'd3,
      S_RWAIT = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [WK_W-1:0]       wake_cnt;
   logic [WK_W-1:0]       wake_cnt_nxt;
   logic                  lat_write;
   logic                  lat_write_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic                  rsp_err_nxt;
   logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

`ifdef MRAM_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]       to_cnt;
   logic [TO_W-1:0]       to_cnt_nxt;
`endif

   // Address is aligned when it is a whole multiple of the word size in bytes.
   function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] a);
      return (a % ADDR_WIDTH'(BYTES)) != '0;
   endfunction

   // State, counters, latched request and all outputs: one register stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_OFF;
         wake_cnt      <= '0;
         lat_write     <= 1'b0;
         mram_addr     <= '0;
         mram_wdata    <= '0;
         rsp_err       <= 1'b0;
         rsp_rdata     <= '0;
         rsp_valid     <= 1'b0;
         pwr_ok        <= 1'b0;
         req_ready     <= 1'b0;
         mram_pwr_on   <= 1'b0;
         mram_cs       <= 1'b0;
         mram_write_en <= 1'b0;
         mram_read_en  <= 1'b0;
`ifdef MRAM_CTRL_TIMEOUT_EN
         to_cnt        <= '0;
`endif
      end else begin
         state         <= state_nxt;
         wake_cnt      <= wake_cnt_nxt;
         lat_write     <= lat_write_nxt;
         mram_addr     <= addr_nxt;
         mram_wdata    <= wdata_nxt;
         rsp_err       <= rsp_err_nxt;
         rsp_rdata     <= rsp_rdata_nxt;
         // Outputs are decoded from the next state so they line up with it.
         rsp_valid     <= (state_nxt == S_RESP);
         pwr_ok        <= (state_nxt == S_IDLE) || (state_nxt == S_ISSUE) ||
                          (state_nxt == S_RWAIT) || (state_nxt == S_RESP);
         req_ready     <= (state_nxt == S_IDLE);
         mram_pwr_on   <= (state_nxt != S_OFF);
         mram_cs       <= (state_nxt == S_ISSUE);
         mram_write_en <= (state_nxt == S_ISSUE) && lat_write_nxt;
         mram_read_en  <= (state_nxt == S_ISSUE) && !lat_write_nxt;
`ifdef MRAM_CTRL_TIMEOUT_EN
         to_cnt        <= to_cnt_nxt;
`endif
      end
   end

   // Next-state, counter and request/response data decode.
   always_comb begin
      state_nxt     = state;
      wake_cnt_nxt  = wake_cnt;
      lat_write_nxt = lat_write;
      addr_nxt      = mram_addr;
      wdata_nxt     = mram_wdata;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
`ifdef MRAM_CTRL_TIMEOUT_EN
      to_cnt_nxt    = to_cnt;
`endif

      case (state)
         S_OFF: begin
            wake_cnt_nxt = '0;
            if (pwr_req) begin
               state_nxt = S_WAKE;
            end else begin
               state_nxt = S_OFF;
            end
         end

         S_WAKE: begin
            if (!pwr_req) begin
               state_nxt    = S_OFF;
               wake_cnt_nxt = '0;
            end else if (wake_cnt == WK_W'(WAKE_CYCLES - 1)) begin
               state_nxt    = S_IDLE;
               wake_cnt_nxt = '0;
            end else begin
               wake_cnt_nxt = wake_cnt + WK_W'(1);
            end
         end

         S_IDLE: begin
            // Power-down wins over a request presented in the same cycle.
            if (!pwr_req) begin
               state_nxt = S_OFF;
            end else if (req_valid && req_ready) begin
               lat_write_nxt = req_write;
               addr_nxt      = req_addr;
               wdata_nxt     = req_wdata;
               if (is_misaligned(req_addr)) begin
                  state_nxt     = S_RESP;
                  rsp_err_nxt   = 1'b1;
                  rsp_rdata_nxt = '0;
               end else begin
                  state_nxt = S_ISSUE;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end

         S_ISSUE: begin
            if (lat_write) begin
               state_nxt     = S_RESP;
               rsp_rdata_nxt = '0;
            end else begin
               state_nxt = S_RWAIT;
`ifdef MRAM_CTRL_TIMEOUT_EN
               to_cnt_nxt = '0;
`endif
            end
         end

         S_RWAIT: begin
            if (mram_ready) begin
               state_nxt     = S_RESP;
               rsp_rdata_nxt = mram_rdata;
`ifdef MRAM_CTRL_TIMEOUT_EN
               to_cnt_nxt    = '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               state_nxt     = S_RESP;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
               to_cnt_nxt    = '0;
            end else begin
               to_cnt_nxt = to_cnt + TO_W'(1);
`else
            end else begin
               state_nxt = S_RWAIT;
`endif
            end
         end

         S_RESP: begin
            // A power-down held off during the transaction takes effect here.
            if (pwr_req) begin
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_OFF;
            end
         end

         default: begin
            state_nxt = S_OFF;
         end
      endcase
   end

endmodule

// File: tb/tb_mram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mram_ctrl -- directed self-checking bench for mram_ctrl (default params).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mram_ctrl;

   localparam int AW = 32;
   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          pwr_req;
   logic          pwr_ok;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          mram_pwr_on;
   logic          mram_cs;
   logic          mram_write_en;
   logic          mram_read_en;
   logic [AW-1:0] mram_addr;
   logic [DW-1:0] mram_wdata;
   logic [DW-1:0] mram_rdata;
   logic          mram_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mram_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAKE_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .pwr_req(pwr_req), .pwr_ok(pwr_ok),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .mram_pwr_on(mram_pwr_on),
      .mram_cs(mram_cs), .mram_write_en(mram_write_en),
      .mram_read_en(mram_read_en), .mram_addr(mram_addr),
      .mram_wdata(mram_wdata), .mram_rdata(mram_rdata),
      .mram_ready(mram_ready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present one request for a single cycle; returns at the falling edge of T+1.
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      step(1);
      req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; pwr_req = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; mram_rdata = '0; mram_ready = 1'b0;
      step(2);
      check("rst_pwr_on", mram_pwr_on, 1'b0);
      check("rst_pwr_ok", pwr_ok, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rdata", rsp_rdata, 64'h0);

      // Power-up: WAKE for exactly 4 cycles.
      rst = 1'b0; pwr_req = 1'b1;
      step(1);
      check("wake_pwr_on", mram_pwr_on, 1'b1);
      check("wake_pwr_ok_c1", pwr_ok, 1'b0);
      step(3);
      check("wake_pwr_ok_c4", pwr_ok, 1'b0);
      step(1);
      check("idle_pwr_ok", pwr_ok, 1'b1);
      check("idle_ready", req_ready, 1'b1);

      // Aligned write: ISSUE at T+1, response at T+2.
      send(1'b1, 32'h40, 64'hDEADBEEF_CAFEF00D);
      check("wr_cs", mram_cs, 1'b1);
      check("wr_wen", mram_write_en, 1'b1);
      check("wr_ren", mram_read_en, 1'b0);
      check("wr_addr", mram_addr, 64'h40);
      check("wr_wdata", mram_wdata, 64'hDEADBEEF_CAFEF00D);
      check("wr_ready_busy", req_ready, 1'b0);
      step(1);
      check("wr_rsp_valid", rsp_valid, 1'b1);
      check("wr_rsp_err", rsp_err, 1'b0);
      check("wr_rsp_rdata", rsp_rdata, 64'h0);
      check("wr_cs_off", mram_cs, 1'b0);
      step(1);
      check("wr_rsp_pulse", rsp_valid, 1'b0);
      check("wr_back_idle", req_ready, 1'b1);

      // Stray mram_ready while IDLE changes nothing.
      mram_ready = 1'b1; mram_rdata = 64'h0000_0000_0000_0BAD;
      step(1);
      mram_ready = 1'b0;
      check("stray_rsp_valid", rsp_valid, 1'b0);
      check("stray_rdata", rsp_rdata, 64'h0);
      check("stray_ready", req_ready, 1'b1);

      // Aligned read, MRAM answers two cycles after the strobe cycle.
      send(1'b0, 32'h40, 64'h0);
      check("rd_cs", mram_cs, 1'b1);
      check("rd_ren", mram_read_en, 1'b1);
      check("rd_wen", mram_write_en, 1'b0);
      step(1);
      check("rd_cs_once", mram_cs, 1'b0);
      check("rd_wait_no_rsp", rsp_valid, 1'b0);
      step(2);
      mram_ready = 1'b1; mram_rdata = 64'hDEADBEEF_CAFEF00D;
      step(1);
      mram_ready = 1'b0; mram_rdata = '0;
      check("rd_rsp_valid", rsp_valid, 1'b1);
      check("rd_rsp_err", rsp_err, 1'b0);
      check("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
      step(1);
      check("rd_rsp_pulse", rsp_valid, 1'b0);
      check("rd_rdata_hold", rsp_rdata, 64'hDEADBEEF_CAFEF00D);

      // Misaligned read: error response at T+1, no MRAM access.
      send(1'b0, 32'h43, 64'h0);
      check("mis_cs", mram_cs, 1'b0);
      check("mis_ren", mram_read_en, 1'b0);
      check("mis_rsp_valid", rsp_valid, 1'b1);
      check("mis_rsp_err", rsp_err, 1'b1);
      check("mis_rsp_rdata", rsp_rdata, 64'h0);
      step(1);

      // Read against an MRAM that never answers.
      send(1'b0, 32'h80, 64'h0);
`ifdef MRAM_CTRL_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (!rsp_valid && n < 40) begin
            step(1);
            n++;
         end
         check("to_latency", 64'(n), 64'd17);
         check("to_rsp_err", rsp_err, 1'b1);
         check("to_rsp_rdata", rsp_rdata, 64'h0);
      end
      step(1);
      send(1'b0, 32'h80, 64'h0);
      step(1);
`else
      begin
         logic seen;
         seen = 1'b0;
         repeat (40) begin
            step(1);
            if (rsp_valid) seen = 1'b1;
         end
         check("no_timeout_rsp", seen, 1'b0);
      end
`endif

      // Power-down during RWAIT is deferred until the response.
      pwr_req = 1'b0;
      step(3);
      check("defer_pwr_on", mram_pwr_on, 1'b1);
      check("defer_no_rsp", rsp_valid, 1'b0);
      mram_ready = 1'b1; mram_rdata = 64'h01234567_89ABCDEF;
      step(1);
      mram_ready = 1'b0;
      check("defer_rsp_valid", rsp_valid, 1'b1);
      check("defer_rsp_rdata", rsp_rdata, 64'h01234567_89ABCDEF);
      check("defer_pwr_on_resp", mram_pwr_on, 1'b1);
      step(1);
      check("defer_off_pwr_on", mram_pwr_on, 1'b0);
      check("defer_off_pwr_ok", pwr_ok, 1'b0);
      check("defer_off_hold", rsp_rdata, 64'h01234567_89ABCDEF);

      // Reset in the middle of RWAIT aborts the read without a response.
      pwr_req = 1'b1;
      step(5);
      check("re_idle_ready", req_ready, 1'b1);
      send(1'b0, 32'h100, 64'h0);
      step(1);
      rst = 1'b1;
      step(1);
      check("mid_rst_pwr_on", mram_pwr_on, 1'b0);
      check("mid_rst_rsp_valid", rsp_valid, 1'b0);
      check("mid_rst_rdata", rsp_rdata, 64'h0);
      check("mid_rst_addr", mram_addr, 64'h0);
      check("mid_rst_pwr_ok", pwr_ok, 1'b0);
      rst = 1'b0; mram_ready = 1'b1;
      step(1);
      mram_ready = 1'b0;
      check("post_rst_no_rsp", rsp_valid, 1'b0);
      check("post_rst_wake", mram_pwr_on, 1'b1);
      step(4);
      check("post_rst_idle", req_ready, 1'b1);

      // In IDLE, power-down takes priority over a simultaneous request.
      pwr_req = 1'b0;
      send(1'b1, 32'h200, 64'h55);
      check("prio_cs", mram_cs, 1'b0);
      check("prio_pwr_on", mram_pwr_on, 1'b0);
      check("prio_ready", req_ready, 1'b0);
      step(2);
      check("prio_no_rsp", rsp_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
